wb_multiplier: RTL and testbench

Wishbone-slave 32×32→64-bit sequential multiplier in the Caravel user project area. Firmware on the management core writes two operands, starts the operation, polls status and reads the 64-bit product. Signed and unsigned modes are supported. The block is the arithmetic target of the chip-level multiplier test, whose firmware reports pass/fail on `mprj_io[37:32]`.

---
 rtl/wb_multiplier_pkg.sv | 20 ++
 rtl/wb_multiplier_core.sv | 84 ++++++++
 rtl/wb_multiplier.sv | 71 +++++++
 tb/tb_wb_multiplier.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/wb_multiplier_pkg.sv
// wb_multiplier_pkg: register map, control bits, FSM states and byte-merge helper
package wb_multiplier_pkg;
   localparam int MUL_ITER = 32;
   localparam logic [4:0] OFS_OPA    = 5'h00;
   localparam logic [4:0] OFS_OPB    = 5'h04;
   localparam logic [4:0] OFS_CTRL   = 5'h08;
   localparam logic [4:0] OFS_RES_LO = 5'h0C;
   localparam logic [4:0] OFS_RES_HI = 5'h10;
   localparam int CTRL_START  = 0;
   localparam int CTRL_SIGNED = 1;
   localparam int STAT_BUSY   = 0;
   localparam int STAT_DONE   = 1;
   localparam int STAT_SIGNED = 2;
   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_v, input logic [31:0] new_v, input logic [3:0] sel);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = sel[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
      return r;
   endfunction
endpackage

// File: rtl/wb_multiplier_core.sv
// mul_seq_core: radix-2 shift-add 32x32 multiplier with sign-magnitude fixup
module mul_seq_core
   import wb_multiplier_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        signed_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        signed_o,
   output logic [63:0] res_o
);
   localparam logic [4:0] LAST = 5'(MUL_ITER - 1);
   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [63:0] acc_q, acc_d, mcand_q, mcand_d;
   logic [31:0] mplier_q, mplier_d, mag_a, mag_b;
   logic        neg_q, neg_d, sgn_q, sgn_d, done_q, done_d;
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         neg_q    <= 1'b0;
         sgn_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         neg_q    <= neg_d;
         sgn_q    <= sgn_d;
         done_q   <= done_d;
      end
   end
   always_comb begin
      mag_a    = (signed_i && a_i[31]) ? -a_i : a_i;
      mag_b    = (signed_i && b_i[31]) ? -b_i : b_i;
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      neg_d    = neg_q;
      sgn_d    = sgn_q;
      done_d   = done_q;
      case (state_q)
         IDLE: if (start_i) begin
            state_d  = RUN;
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = {32'd0, mag_a};
            mplier_d = mag_b;
            neg_d    = signed_i & (a_i[31] ^ b_i[31]);
            sgn_d    = signed_i;
            done_d   = 1'b0;
         end
         RUN: begin
            acc_d    = mplier_q[0] ? acc_q + mcand_q : acc_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 5'd1;
            state_d  = (cnt_q == LAST) ? FIX : RUN;
         end
         FIX: begin
            acc_d   = neg_q ? -acc_q : acc_q;
            state_d = IDLE;
            done_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end
   assign busy_o   = state_q != IDLE;
   assign done_o   = done_q;
   assign signed_o = sgn_q;
   assign res_o    = acc_q;
endmodule

// File: rtl/wb_multiplier.sv
// wb_multiplier: Wishbone register front end around the sequential multiplier core
module wb_multiplier
   import wb_multiplier_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic        irq_o
);
   logic [31:0] opa_q, opa_d, opb_q, opb_d, dat_q, dat_d, status, rdata;
   logic        ack_q, req, wr, start, busy, done, sgn;
   logic [4:0]  ofs;
   logic [63:0] res;
   logic        unused_adr;
   assign unused_adr = ^wbs_adr_i[1:0];
   always_comb begin
      ofs    = {wbs_adr_i[4:2], 2'b00};
      req    = wbs_cyc_i & wbs_stb_i & ~ack_q & (wbs_adr_i[31:5] == BASE_ADDR[31:5]);
      wr     = req & wbs_we_i;
      opa_d  = (wr && ofs == OFS_OPA) ? merge_bytes(opa_q, wbs_dat_i, wbs_sel_i) : opa_q;
      opb_d  = (wr && ofs == OFS_OPB) ? merge_bytes(opb_q, wbs_dat_i, wbs_sel_i) : opb_q;
      start  = wr && ofs == OFS_CTRL && wbs_sel_i[0] && wbs_dat_i[CTRL_START];
      status = '0;
      status[STAT_BUSY]   = busy;
      status[STAT_DONE]   = done;
      status[STAT_SIGNED] = sgn;
      rdata  = (ofs == OFS_OPA)    ? opa_q      :
               (ofs == OFS_OPB)    ? opb_q      :
               (ofs == OFS_CTRL)   ? status     :
               (ofs == OFS_RES_LO) ? res[31:0]  :
               (ofs == OFS_RES_HI) ? res[63:32] : '0;
      dat_d  = (req && !wbs_we_i) ? rdata : '0;
   end
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         opa_q <= '0;
         opb_q <= '0;
         ack_q <= 1'b0;
         dat_q <= '0;
      end else begin
         opa_q <= opa_d;
         opb_q <= opb_d;
         ack_q <= req;
         dat_q <= dat_d;
      end
   end
   mul_seq_core u_core (
      .clk_i    (wb_clk_i),
      .rst_i    (wb_rst_i),
      .start_i  (start),
      .signed_i (wbs_dat_i[CTRL_SIGNED]),
      .a_i      (opa_q),
      .b_i      (opb_q),
      .busy_o   (busy),
      .done_o   (done),
      .signed_o (sgn),
      .res_o    (res)
   );
   assign wbs_ack_o = ack_q;
   assign wbs_dat_o = dat_q;
   assign irq_o     = done;
endmodule

// File: tb/tb_wb_multiplier.sv
// tb_wb_multiplier: directed and random Wishbone tests against an arithmetic product model
module tb_wb_multiplier;
   localparam logic [31:0] BASE = 32'h3000_0000;
   localparam logic [31:0] A_OPA = BASE + 32'h00, A_OPB = BASE + 32'h04, A_CTRL = BASE + 32'h08;
   localparam logic [31:0] A_LO = BASE + 32'h0C, A_HI = BASE + 32'h10, A_RSV = BASE + 32'h14;
   logic        clk = 1'b0, rst = 1'b1, cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [3:0]  sel = 4'hF;
   logic [31:0] adr = '0, dat = '0;
   logic        ack, irq;
   logic [31:0] dat_o;
   int          n_cmp = 0, n_err = 0, cyc_n = 0;
   wb_multiplier #(.BASE_ADDR(BASE)) dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (rst),
      .wbs_cyc_i (cyc),
      .wbs_stb_i (stb),
      .wbs_we_i  (we),
      .wbs_sel_i (sel),
      .wbs_adr_i (adr),
      .wbs_dat_i (dat),
      .wbs_ack_o (ack),
      .wbs_dat_o (dat_o),
      .irq_o     (irq)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc_n <= cyc_n + 1;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sg);
      longint sa, sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return sg ? 64'(sa * sb) : {32'd0, a} * {32'd0, b};
   endfunction
   task automatic bus(input logic w, input logic [31:0] ad, input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rd, output logic acked);
      cyc = 1'b1; stb = 1'b1; we = w; adr = ad; dat = d; sel = s;
      acked = 1'b0; rd = '0;
      for (int i = 0; i < 8 && !acked; i++) begin
         @(posedge clk); #1;
         if (ack) begin acked = 1'b1; rd = dat_o; end
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'hF;
   endtask
   task automatic wr(input logic [31:0] ad, input logic [31:0] d, input logic [3:0] s = 4'hF);
      logic [31:0] rd;
      logic        a;
      bus(1'b1, ad, d, s, rd, a);
      chk("write_ack", a, 1);
   endtask
   task automatic rd_chk(input string tag, input logic [31:0] ad, input logic [31:0] exp);
      logic [31:0] rd;
      logic        a;
      bus(1'b0, ad, '0, 4'hF, rd, a);
      chk({tag, "_ack"}, a, 1);
      chk(tag, rd, exp);
   endtask
   task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic sg, output int t0);
      wr(A_OPA, a);
      wr(A_OPB, b);
      wr(A_CTRL, {30'd0, sg, 1'b1});
      t0 = cyc_n;
   endtask
   task automatic finish_op(input int t0, input logic [31:0] a, input logic [31:0] b, input logic sg);
      logic [63:0] exp;
      int          n;
      exp = model(a, b, sg);
      n = 0;
      while (!irq && n < 200) begin @(posedge clk); #1; n++; end
      chk("done_latency", 64'(cyc_n - t0), 33);
      chk("irq", irq, 1);
      rd_chk("status_done", A_CTRL, {29'd0, sg, 2'b10});
      rd_chk("res_lo", A_LO, exp[31:0]);
      rd_chk("res_hi", A_HI, exp[63:32]);
   endtask
   task automatic full_op(input logic [31:0] a, input logic [31:0] b, input logic sg);
      int t0;
      start_op(a, b, sg, t0);
      rd_chk("status_busy", A_CTRL, {29'd0, sg, 2'b01});
      finish_op(t0, a, b, sg);
   endtask
   initial begin
      int          t0;
      logic [31:0] rd, ra, rb;
      logic        a;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_ack", ack, 0);
      chk("rst_dat", dat_o, 0);
      chk("rst_irq", irq, 0);
      rd_chk("rst_status", A_CTRL, 0);
      rd_chk("rst_opa", A_OPA, 0);
      rd_chk("rst_res_hi", A_HI, 0);
      full_op(32'd7, 32'd6, 1'b0);
      @(posedge clk); #1;
      chk("ack_one_cycle", ack, 0);
      chk("dat_idle_zero", dat_o, 0);
      full_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      full_op(32'hFFFF_FFFD, 32'd5, 1'b1);
      full_op(32'h8000_0000, 32'h8000_0000, 1'b1);
      wr(A_LO, 32'hDEAD_BEEF);
      rd_chk("res_lo_readonly", A_LO, 32'h0);
      wr(A_RSV, 32'h1234_5678);
      rd_chk("reserved_zero", A_RSV, 0);
      bus(1'b0, BASE + 32'h20, '0, 4'hF, rd, a);
      chk("out_of_window_noack", a, 0);
      start_op(32'd2, 32'd3, 1'b0, t0);
      while (cyc_n - t0 < 10) begin @(posedge clk); #1; end
      wr(A_OPA, 32'd100);
      wr(A_OPB, 32'd100);
      wr(A_CTRL, 32'h1);
      finish_op(t0, 32'd2, 32'd3, 1'b0);
      rd_chk("opa_written_busy", A_OPA, 32'd100);
      wr(A_OPA, 32'h1122_3344);
      wr(A_OPA, 32'h0000_AB00, 4'b0010);
      rd_chk("byte_lane", A_OPA, 32'h1122_AB44);
      wr(A_CTRL, 32'h1, 4'b0010);
      rd_chk("ctrl_sel0_needed", A_CTRL, {29'd0, 3'b010});
      start_op(32'd7, 32'd6, 1'b0, t0);
      while (cyc_n - t0 < 15) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_irq", irq, 0);
      rd_chk("abort_status", A_CTRL, 0);
      rd_chk("abort_res_lo", A_LO, 0);
      rd_chk("abort_res_hi", A_HI, 0);
      rd_chk("abort_opa", A_OPA, 0);
      full_op(32'd7, 32'd6, 1'b0);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_OPA; rst = 1'b1;
      @(posedge clk); #1;
      chk("reset_beats_req", ack, 0);
      cyc = 1'b0; stb = 1'b0; rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         ra = $urandom;
         rb = $urandom;
         if (i == 0) ra = 32'h8000_0000;
         full_op(ra, rb, 1'($urandom_range(0, 1)));
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
